gg_deblock_writeback: RTL and testbench
=======================================

// Module: gg_deblock_writeback
// PURPOSE
//  Sink for gg_deblock_process outputs. Each cycle the deblocker may emit 0-4 filtered 4x4 blocks (above-left, above, left, current)
//  relative to the block presented at its input. This block maps each to an absolute tile, buffers up to 4 pushes/cycle in a FIFO, and
//  drains one 128-bit tile per cycle to a frame-store write port with valid/ready. Raises frame_done after the last tile of the frame.
// PARAMETERS
//  DEPTH   16  FIFO entries (power of 2, >=8)
//  ADDR_W  21  tile address width (16-byte tile units)
// PORTS
//  clk          in   1      clock
//  reset        in   1      synchronous, active-high
//  frame_start  in   1      pulse: latch mb_width/mb_height, clear counters/errors
//  mb_width     in   8      picture width in MBs minus 1
//  mb_height    in   8      picture height in MBs minus 1
//  mbx, mby     in   8,8    MB position of block at deblocker input this cycle
//  cidx         in   3      0-luma, 2-cb, 3-cr (others: no position; any valid flag -> err_protocol)
//  bidx         in   4      H.264 block index of input block
//  ale_valid/abv_valid/lef_valid/cur_valid  in 1 each  deblocker output valids
//  ale_filt/abv_filt/lef_filt/cur_filt      in 128 each filtered tiles, byte 0 = top-left, raster
//  blk_ready    out  1      registered: FIFO free >= 4; upstream issues new input block only when high
//  wr_valid     out  1      write request
//  wr_ready     in   1      frame store accepts
//  wr_addr      out  ADDR_W tile address
//  wr_data      out  128    tile data
//  frame_done   out  1      one-cycle pulse
//  err_overflow out  1      sticky: push dropped, FIFO full
//  err_protocol out  1      sticky: off-picture neighbour, bad cidx, or valid outside RUN
// BEHAVIOUR
//  Reset: all outputs 0 except blk_ready=1; FIFO empty; state IDLE. Reset mid-frame discards all pending tiles.
//  FSM: IDLE -frame_start-> RUN -last tile accepted-> DONE (1 cycle, frame_done=1) -> IDLE. frame_start in RUN: ignored, err_protocol=1.
//  Valid flags in IDLE/DONE: tiles dropped, err_protocol=1.
//  Input tile coords (4x4 units): luma bx={bidx[2],bidx[0]}, by={bidx[3],bidx[1]}, X=mbx*4+bx, Y=mby*4+by;
//   chroma bx=bidx[0], by=bidx[1], X=mbx*2+bx, Y=mby*2+by. Neighbours: ale (X-1,Y-1), abv (X,Y-1), lef (X-1,Y), cur (X,Y); same plane.
//  Negative coordinate: tile dropped, err_protocol=1.
//  Strides latched at frame_start: SY=(mb_width+1)*4, SC=(mb_width+1)*2; bases: Cb=SY*(mb_height+1)*4, Cr=Cb+SC*(mb_height+1)*2.
//  addr: Y: Y*SY+X; Cb: Cb+Y*SC+X; Cr: Cr+Y*SC+X; truncated to ADDR_W.
//  Push order within a cycle: ale, abv, lef, cur (lower FIFO slots first). Pushes beyond free space: excess dropped (in that order), err_overflow=1.
//  Latency: tile sampled at edge N is earliest wr_valid at N+1. wr_addr/wr_data stable while wr_valid & !wr_ready.
//  Push and pop same cycle: free space counted after the pop.
//  Tile counter (21b) increments per accepted write; target=(mb_width+1)*(mb_height+1)*24; on reach -> DONE, counter cleared.
//  Errors cleared only by reset or frame_start.
// CONFIGURATION
//  GG_WB_CHECKSUM_EN defined: add out port wr_checksum [31:0]: cleared at frame_start; each accepted write adds sum of 16 data bytes
//   (mod 2^32); value held through IDLE. Undefined: port absent, no adder logic.
// STRUCTURE
//  gg_deblock_pkg: plane enum (Y,CB,CR), cidx constants, blk_xy luma/chroma functions, tile_t (logic [0:15][7:0]).
//  Sub-module gg_wb_fifo: 4-push/1-pop FIFO of {addr,data}, push mask in, free count out. Top: coords, addressing, FSM, counters.
// TESTING
//  1 mb_width=2,mb_height=2, frame_start; mbx=0,mby=0,cidx=0,bidx=3, ale_valid -> next cycle wr_valid, wr_addr=0, data=ale_filt.
//  2 same frame: mbx=1,mby=0,cidx=2,bidx=1, cur_valid -> wr_addr=144+3=147; cidx=3 same -> 180+3=183.
//  3 all four valid, luma bidx=15,mbx=1,mby=1, wr_ready=1 -> 4 writes in order addrs 6*12+6=78, 79, 90, 91; blk_ready low one cycle at most if FIFO had >12 used.
//  4 wr_ready=0 with 5 cycles of 4-tile pushes, DEPTH=16 -> 16 stored, 4 dropped, err_overflow=1, blk_ready=0; release -> 16 writes in order.
//  5 mbx=0,mby=0,bidx=0, ale_valid -> no write, err_protocol=1; frame_start clears it.
//  6 full 3x3-MB frame, 216 tiles written -> frame_done pulse exactly once after 216th accept; checksum (if GG_WB_CHECKSUM_EN) = bench byte sum.

Source files
------------

// File: rtl/gg_deblock_pkg.sv
// Shared types and helpers for the deblock writeback path: plane/state enums, cidx codes,
// block-index to 4x4 tile position decoding and the byte-sum used by the optional checksum.
package gg_deblock_pkg;

  typedef enum logic [1:0] {PLANE_Y, PLANE_CB, PLANE_CR} plane_e;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} wb_state_e;

  localparam logic [2:0] CIDX_Y  = 3'd0;
  localparam logic [2:0] CIDX_CB = 3'd2;
  localparam logic [2:0] CIDX_CR = 3'd3;

  typedef logic [0:15][7:0] tile_t;

  // Returns {by[1:0], bx[1:0]} of a luma 4x4 block inside its MB.
  function automatic logic [3:0] blk_xy_luma(input logic [3:0] bidx);
    return {bidx[3], bidx[1], bidx[2], bidx[0]};
  endfunction

  // Returns {by, bx} of a chroma 4x4 block inside its MB.
  function automatic logic [1:0] blk_xy_chroma(input logic [3:0] bidx);
    return {bidx[1], bidx[0]};
  endfunction

  function automatic logic [31:0] tile_byte_sum(input tile_t t);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < 16; i++) s = s + 32'(t[i]);
    return s;
  endfunction

endpackage

// File: rtl/gg_wb_fifo.sv
// Four-push / one-pop FIFO. Masked push slots are packed in slot order into the free space left
// after this cycle's pop; slots that do not fit are dropped and flagged.
module gg_wb_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 149
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              push_mask,
  input  logic [3:0][W-1:0]       push_data,
  input  logic                    pop,
  output logic                    valid,
  output logic [W-1:0]            head,
  output logic [$clog2(DEPTH):0]  free,
  output logic                    drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]         mem [DEPTH];
  logic [AW-1:0]        wptr_q, rptr_q;
  logic [CW-1:0]        count_q, count_d, room;
  logic [3:0]           slot_we;
  logic [3:0][AW-1:0]   slot_idx;
  logic [2:0]           n;
  logic                 do_pop;

  assign valid  = (count_q != '0);
  assign do_pop = pop & valid;
  assign head   = mem[rptr_q];

  always_comb begin
    room     = CW'(DEPTH) - count_q + CW'(do_pop);
    n        = '0;
    slot_we  = '0;
    slot_idx = '0;
    drop     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (push_mask[i]) begin
        if (CW'(n) < room) begin
          slot_we[i]  = 1'b1;
          slot_idx[i] = wptr_q + AW'(n);
          n           = n + 3'd1;
        end else begin
          drop = 1'b1;
        end
      end
    end
    count_d = count_q + CW'(n) - CW'(do_pop);
    free    = CW'(DEPTH) - count_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_q + AW'(n);
      rptr_q  <= rptr_q + AW'(do_pop);
      count_q <= count_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (slot_we[i]) mem[slot_idx[i]] <= push_data[i];
    end
  end

endmodule

// File: rtl/gg_deblock_writeback.sv
// Deblocker output sink: maps up to four filtered tiles per cycle to frame-store tile addresses,
// queues them and drains one per cycle. Optional running byte checksum under GG_WB_CHECKSUM_EN.
module gg_deblock_writeback
  import gg_deblock_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 21
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic [7:0]        mb_width,
  input  logic [7:0]        mb_height,
  input  logic [7:0]        mbx,
  input  logic [7:0]        mby,
  input  logic [2:0]        cidx,
  input  logic [3:0]        bidx,
  input  logic              ale_valid,
  input  logic              abv_valid,
  input  logic              lef_valid,
  input  logic              cur_valid,
  input  logic [127:0]      ale_filt,
  input  logic [127:0]      abv_filt,
  input  logic [127:0]      lef_filt,
  input  logic [127:0]      cur_filt,
  output logic              blk_ready,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [127:0]      wr_data,
`ifdef GG_WB_CHECKSUM_EN
  output logic [31:0]       wr_checksum,
`endif
  output logic              frame_done,
  output logic              err_overflow,
  output logic              err_protocol,
  output wb_state_e         dbg_state
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = ADDR_W + 128;

  // Write port: a tile transfers on a clock edge where wr_valid and wr_ready are both high;
  // wr_addr/wr_data hold steady while wr_valid is high and wr_ready is low.
  wb_state_e           state_q, state_d;
  logic [ADDR_W-1:0]   sy_q, sc_q, cb_base_q, cr_base_q;
  logic [ADDR_W-1:0]   w1, h1, wh, stride, base, a_cur;
  logic [20:0]         tile_cnt_q, tile_target_q;
  logic [3:0]          lxy, in_valid, off, push_mask;
  logic [1:0]          cxy;
  logic [9:0]          tx, ty;
  plane_e              plane;
  logic                cidx_ok, run, start_ok, accept, proto_hit, drop;
  logic [3:0][EW-1:0]  push_data;
  logic [EW-1:0]       head;
  logic [CW-1:0]       free;
  logic [3:0][ADDR_W-1:0] addr;

  assign run      = (state_q == ST_RUN);
  assign start_ok = frame_start & ~run;
  assign accept   = wr_valid & wr_ready;
  assign w1       = ADDR_W'(mb_width) + ADDR_W'(1);
  assign h1       = ADDR_W'(mb_height) + ADDR_W'(1);
  assign wh       = w1 * h1;
  assign lxy      = blk_xy_luma(bidx);
  assign cxy      = blk_xy_chroma(bidx);

  always_comb begin
    plane   = PLANE_Y;
    cidx_ok = 1'b1;
    tx      = {mbx, lxy[1:0]};
    ty      = {mby, lxy[3:2]};
    case (cidx)
      CIDX_Y:  ;
      CIDX_CB: begin plane = PLANE_CB; tx = {1'b0, mbx, cxy[0]}; ty = {1'b0, mby, cxy[1]}; end
      CIDX_CR: begin plane = PLANE_CR; tx = {1'b0, mbx, cxy[0]}; ty = {1'b0, mby, cxy[1]}; end
      default: cidx_ok = 1'b0;
    endcase
  end

  assign stride = (plane == PLANE_Y) ? sy_q : sc_q;
  assign base   = (plane == PLANE_CB) ? cb_base_q : (plane == PLANE_CR) ? cr_base_q : '0;
  assign a_cur  = base + ADDR_W'(ty) * stride + ADDR_W'(tx);

  // Neighbours sit one row above and/or one column left of the current tile in the same plane.
  assign addr[0]  = a_cur - stride - ADDR_W'(1);
  assign addr[1]  = a_cur - stride;
  assign addr[2]  = a_cur - ADDR_W'(1);
  assign addr[3]  = a_cur;
  assign in_valid = {cur_valid, lef_valid, abv_valid, ale_valid};
  assign off      = {1'b0, (tx == '0), (ty == '0), (tx == '0) | (ty == '0)};
  assign push_mask = in_valid & ~off & {4{run & cidx_ok}};
  assign proto_hit = ((|in_valid) & (~run | ~cidx_ok | (|(in_valid & off)))) | (frame_start & run);

  assign push_data[0] = {addr[0], ale_filt};
  assign push_data[1] = {addr[1], abv_filt};
  assign push_data[2] = {addr[2], lef_filt};
  assign push_data[3] = {addr[3], cur_filt};

  gg_wb_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_mask (push_mask),
    .push_data (push_data),
    .pop       (wr_ready),
    .valid     (wr_valid),
    .head      (head),
    .free      (free),
    .drop      (drop)
  );

  assign wr_addr    = wr_valid ? head[EW-1:128] : '0;
  assign wr_data    = wr_valid ? head[127:0] : '0;
  assign frame_done = (state_q == ST_DONE);
  assign dbg_state  = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (frame_start) state_d = ST_RUN;
      ST_RUN:  if (accept && (tile_cnt_q + 21'd1 == tile_target_q)) state_d = ST_DONE;
      ST_DONE: state_d = frame_start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      blk_ready     <= 1'b1;
      err_overflow  <= 1'b0;
      err_protocol  <= 1'b0;
      tile_cnt_q    <= '0;
      tile_target_q <= '0;
      sy_q          <= '0;
      sc_q          <= '0;
      cb_base_q     <= '0;
      cr_base_q     <= '0;
    end else begin
      state_q      <= state_d;
      blk_ready    <= (free >= CW'(4));
      err_overflow <= (start_ok ? 1'b0 : err_overflow) | drop;
      err_protocol <= (start_ok ? 1'b0 : err_protocol) | proto_hit;
      if (start_ok) begin
        tile_cnt_q    <= '0;
        tile_target_q <= (21'(mb_width) + 21'd1) * (21'(mb_height) + 21'd1) * 21'd24;
        sy_q          <= w1 << 2;
        sc_q          <= w1 << 1;
        cb_base_q     <= wh << 4;
        cr_base_q     <= (wh << 4) + (wh << 2);
      end else if (run && accept) begin
        tile_cnt_q <= (tile_cnt_q + 21'd1 == tile_target_q) ? '0 : tile_cnt_q + 21'd1;
      end
    end
  end

`ifdef GG_WB_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset || start_ok) wr_checksum <= '0;
    else if (accept)       wr_checksum <= wr_checksum + tile_byte_sum(wr_data);
  end
`endif

endmodule

// File: tb/tb_gg_deblock_writeback.sv
// Directed bench for gg_deblock_writeback with a queue scoreboard of expected {addr,data} writes.
module tb_gg_deblock_writeback;
  import gg_deblock_pkg::*;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 21;
  localparam int EW     = ADDR_W + 128;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic frame_start = 1'b0;
  logic [7:0] mb_width = '0, mb_height = '0, mbx = '0, mby = '0;
  logic [2:0] cidx = '0;
  logic [3:0] bidx = '0;
  logic ale_valid = 1'b0, abv_valid = 1'b0, lef_valid = 1'b0, cur_valid = 1'b0;
  logic [127:0] ale_filt = '0, abv_filt = '0, lef_filt = '0, cur_filt = '0;
  logic blk_ready, wr_valid, frame_done, err_overflow, err_protocol;
  logic wr_ready = 1'b1;
  logic [ADDR_W-1:0] wr_addr;
  logic [127:0] wr_data;
  wb_state_e dbg_state;
`ifdef GG_WB_CHECKSUM_EN
  logic [31:0] wr_checksum;
`endif

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  int w_mb = 0, h_mb = 0;
  logic in_run = 1'b0, exp_ovf = 1'b0, exp_prot = 1'b0;
  int frame_acc = 0, done_cnt = 0, done_acc = -1;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [31:0] exp_csum = '0;

  gg_deblock_writeback #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .mb_width(mb_width), .mb_height(mb_height), .mbx(mbx), .mby(mby),
    .cidx(cidx), .bidx(bidx),
    .ale_valid(ale_valid), .abv_valid(abv_valid), .lef_valid(lef_valid), .cur_valid(cur_valid),
    .ale_filt(ale_filt), .abv_filt(abv_filt), .lef_filt(lef_filt), .cur_filt(cur_filt),
    .blk_ready(blk_ready), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef GG_WB_CHECKSUM_EN
    .wr_checksum(wr_checksum),
`endif
    .frame_done(frame_done), .err_overflow(err_overflow), .err_protocol(err_protocol),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] bsum(input logic [127:0] d);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < 16; i++) s = s + 32'(d[i*8 +: 8]);
    return s;
  endfunction

  // Scoreboard: a write handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (wr_valid && wr_ready) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_write observed_addr=%0h expected=none", wr_addr);
        end
        if (exp_q.size() != 0) begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          check("wr_tile", {wr_addr, wr_data}, e);
          exp_csum = exp_csum + bsum(e[127:0]);
        end
        frame_acc++;
        last_addr = wr_addr;
      end
      if (frame_done) begin
        done_cnt++;
        done_acc = frame_acc;
        in_run = 1'b0;
      end
    end
  end

  // Drivers
  task automatic apply_reset();
    reset = 1'b1;
    exp_q.delete();
    {ale_valid, abv_valid, lef_valid, cur_valid} = '0;
    frame_start = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    in_run = 1'b0;
    exp_ovf = 1'b0;
    exp_prot = 1'b0;
  endtask

  task automatic start_frame(input int w, input int h);
    mb_width = 8'(w);
    mb_height = 8'(h);
    frame_start = 1'b1;
    if (!in_run) begin
      w_mb = w; h_mb = h;
      exp_ovf = 1'b0; exp_prot = 1'b0;
      frame_acc = 0; exp_csum = '0; in_run = 1'b1;
    end else begin
      exp_prot = 1'b1;
    end
    tick();
    frame_start = 1'b0;
  endtask

  // m[0]=ale, m[1]=abv, m[2]=lef, m[3]=cur
  task automatic drive(input int x, input int y, input int c, input int b, input logic [3:0] m);
    logic [127:0] d [4];
    logic [3:0] bb;
    int bx, by, tx, ty, s, base, room, dx, dy;
    bb = 4'(b);
    for (int i = 0; i < 4; i++) d[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
    mbx = 8'(x); mby = 8'(y); cidx = 3'(c); bidx = bb;
    {cur_valid, lef_valid, abv_valid, ale_valid} = m;
    ale_filt = d[0]; abv_filt = d[1]; lef_filt = d[2]; cur_filt = d[3];
    if (c == 0) begin
      bx = {bb[2], bb[0]}; by = {bb[3], bb[1]};
      tx = x * 4 + bx; ty = y * 4 + by; s = (w_mb + 1) * 4; base = 0;
    end else begin
      bx = bb[0]; by = bb[1];
      tx = x * 2 + bx; ty = y * 2 + by; s = (w_mb + 1) * 2;
      base = (w_mb + 1) * 4 * (h_mb + 1) * 4;
      if (c == 3) base = base + s * (h_mb + 1) * 2;
    end
    room = DEPTH - exp_q.size() + ((wr_ready && exp_q.size() > 0) ? 1 : 0);
    if (m != 4'b0000 && (!in_run || !(c == 0 || c == 2 || c == 3))) begin
      exp_prot = 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        dx = (i == 0 || i == 2) ? 1 : 0;
        dy = (i < 2) ? 1 : 0;
        if (m[i]) begin
          if (tx < dx || ty < dy) exp_prot = 1'b1;
          else if (room > 0) begin
            exp_q.push_back({ADDR_W'(base + (ty - dy) * s + tx - dx), d[i]});
            room--;
          end else exp_ovf = 1'b1;
        end
      end
    end
    tick();
    {ale_valid, abv_valid, lef_valid, cur_valid} = '0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL drain_timeout observed_pending=%0d expected=0", exp_q.size());
    end
  endtask

  task automatic wait_ready(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (blk_ready) break;
      tick();
    end
    check("blk_ready_wait", blk_ready, 1'b1);
  endtask

  initial begin
    apply_reset();
    check("rst_wr_valid", wr_valid, 1'b0);
    check("rst_blk_ready", blk_ready, 1'b1);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_err_overflow", err_overflow, 1'b0);
    check("rst_err_protocol", err_protocol, 1'b0);
    check("rst_wr_addr", wr_addr, '0);
    check("rst_wr_data", wr_data, '0);
    check("rst_state", dbg_state, ST_IDLE);

    // Luma above-left neighbour of block 3 in MB(0,0)
    start_frame(2, 2);
    check("t1_state_run", dbg_state, ST_RUN);
    drive(0, 0, 0, 3, 4'b0001);
    check("t1_latency", wr_valid, 1'b1);
    wait_drain(20);
    check("t1_addr", last_addr, 21'd0);

    // Chroma current tiles
    drive(1, 0, 2, 1, 4'b1000);
    wait_drain(20);
    check("t2_cb_addr", last_addr, 21'd147);
    drive(1, 0, 3, 1, 4'b1000);
    wait_drain(20);
    check("t2_cr_addr", last_addr, 21'd183);

    // All four neighbours of luma block 15 in MB(1,1)
    drive(1, 1, 0, 15, 4'b1111);
    wait_drain(20);
    check("t3_last_addr", last_addr, 21'd91);
    check("t3_err_protocol", err_protocol, exp_prot);

    // Overflow with the write port stalled
    wr_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(1, 1, 0, 15, 4'b1111);
      if (exp_q.size() > 0) check("t4_hold", {wr_addr, wr_data}, exp_q[0]);
    end
    check("t4_err_overflow", err_overflow, exp_ovf);
    check("t4_blk_ready_low", blk_ready, 1'b0);
    wr_ready = 1'b1;
    wait_drain(40);
    check("t4_overflow_sticky", err_overflow, exp_ovf);
    check("t4_blk_ready_high", blk_ready, 1'b1);

    // Off-picture neighbour, then frame_start while running
    drive(0, 0, 0, 0, 4'b0001);
    check("t5_err_protocol", err_protocol, exp_prot);
    check("t5_no_write", wr_valid, 1'b0);
    start_frame(2, 2);
    check("t5_start_in_run_err", err_protocol, exp_prot);
    check("t5_state_still_run", dbg_state, ST_RUN);

    // Reset mid-frame discards pending tiles
    wr_ready = 1'b0;
    drive(1, 1, 0, 15, 4'b1111);
    check("rst_mid_pending", wr_valid, 1'b1);
    apply_reset();
    wr_ready = 1'b1;
    check("rst_mid_wr_valid", wr_valid, 1'b0);
    check("rst_mid_err_protocol", err_protocol, 1'b0);
    check("rst_mid_err_overflow", err_overflow, 1'b0);
    tick();
    check("rst_mid_no_write", wr_valid, 1'b0);

    // Full 3x3-MB frame: 16 luma + 4 Cb + 4 Cr tiles per MB
    start_frame(2, 2);
    done_cnt = 0;
    for (int my = 0; my < 3; my++) begin
      for (int mx = 0; mx < 3; mx++) begin
        for (int blk = 0; blk < 24; blk++) begin
          wait_ready(20);
          if (blk < 16)      drive(mx, my, 0, blk, 4'b1000);
          else if (blk < 20) drive(mx, my, 2, blk - 16, 4'b1000);
          else               drive(mx, my, 3, blk - 20, 4'b1000);
        end
      end
    end
    wait_drain(50);
    repeat (3) tick();
    check("t6_done_count", 32'(done_cnt), 32'd1);
    check("t6_done_after", 32'(done_acc), 32'd216);
    check("t6_state_idle", dbg_state, ST_IDLE);
    check("t6_err_protocol", err_protocol, exp_prot);
`ifdef GG_WB_CHECKSUM_EN
    check("t6_checksum", wr_checksum, exp_csum);
`endif

    // Valid outside RUN, cleared by the next frame_start
    drive(1, 1, 0, 15, 4'b1000);
    check("t7_idle_valid_err", err_protocol, exp_prot);
    check("t7_idle_no_write", wr_valid, 1'b0);
    start_frame(2, 2);
    check("t7_start_clears_prot", err_protocol, exp_prot);
    check("t7_start_clears_ovf", err_overflow, exp_ovf);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
